dtcore32_fetch_unit: RTL and testbench

- IF-stage fetch engine for dtcore32.
- Consumes the IF stall and redirect controls produced by the hazard/trap logic.
- Issues in-order instruction-memory requests over a valid/ready handshake and buffers responses in a small FIFO.
- Presents one instruction per cycle to the IF/ID pipeline register, and discards stale in-flight responses after a branch or trap redirect.

---
 rtl/dtcore32_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_dtcore32_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtcore32_fetch_unit.sv
// dtcore32 IF-stage fetch engine: credit-limited in-order imem requests, a small response FIFO
// feeding IF/ID, and discard of stale in-flight responses after a branch or trap redirect.
module dtcore32_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        EX_pc_src_i,
    input  logic [31:0] EX_pc_target_i,
    input  logic        trap_redirect_i,
    input  logic [31:0] trap_pc_i,
    input  logic        IF_stall_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_rdata_i,
    input  logic        imem_rsp_err_i,
    output logic        ID_valid_o,
    output logic [31:0] ID_instr_o,
    output logic [31:0] ID_pc_o,
    output logic [31:0] ID_pc_plus_4_o,
    output logic        ID_fetch_fault_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] RST_HOLD = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] instr_mem [FIFO_DEPTH];
    logic [31:0] pc_mem    [FIFO_DEPTH];
    logic        err_mem   [FIFO_DEPTH];

    logic             redirect;
    logic [31:0]      target;
    logic [CNT_W:0]   in_use;
    logic             credit_ok;
    logic             req_valid;
    logic             accept;
    logic             rsp;
    logic             dropping;
    logic             push;
    logic             pop;
    logic             fifo_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign redirect = trap_redirect_i | EX_pc_src_i;
    assign target   = trap_redirect_i ? {trap_pc_i[31:2], 2'b00} : {EX_pc_target_i[31:2], 2'b00};

    // Every request in flight already owns a FIFO slot, so responses never need backpressure.
    assign in_use    = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit_ok = in_use < (CNT_W + 1)'(FIFO_DEPTH);
    assign req_valid = (state_q != RST_HOLD) & ~redirect & credit_ok;
    assign accept    = req_valid & imem_req_ready_i;

    assign rsp        = imem_rsp_valid_i & (outstanding_q != '0);
    assign dropping   = drop_cnt_q != '0;
    assign fifo_valid = count_q != '0;
    assign push       = rsp & ~dropping & ~redirect;
    assign pop        = fifo_valid & ~IF_stall_i & ~redirect;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (accept) begin
            outstanding_d = outstanding_d + CNT_ONE;
            pc_d          = pc_q + 32'd4;
        end
        if (rsp) begin
            outstanding_d = outstanding_d - CNT_ONE;
        end

        if (redirect) begin
            // Everything still in flight belongs to the old path; a response landing now is
            // already excluded from outstanding_d.
            pc_d       = target;
            rsp_pc_d   = target;
            drop_cnt_d = outstanding_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (rsp && dropping) begin
                drop_cnt_d = drop_cnt_q - CNT_ONE;
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RST_HOLD;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset: ID outputs are gated by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rsp_err_i ? 32'h0000_0000 : imem_rsp_rdata_i;
            pc_mem[wr_ptr_q]    <= rsp_pc_q;
            err_mem[wr_ptr_q]   <= imem_rsp_err_i;
        end
    end

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_q;

    assign ID_valid_o       = fifo_valid;
    assign ID_instr_o       = fifo_valid ? instr_mem[rd_ptr_q] : 32'h0000_0000;
    assign ID_pc_o          = fifo_valid ? pc_mem[rd_ptr_q] : 32'h0000_0000;
    assign ID_pc_plus_4_o   = fifo_valid ? pc_mem[rd_ptr_q] + 32'd4 : 32'h0000_0000;
    assign ID_fetch_fault_o = fifo_valid & err_mem[rd_ptr_q];

endmodule

// File: tb/tb_dtcore32_fetch_unit.sv
// Bench for dtcore32_fetch_unit: in-order memory model with variable latency plus a program-order
// scoreboard for requests and ID output, driven by directed steps and a randomized phase.
module tb_dtcore32_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_pc_src;
    logic [31:0] ex_pc_target;
    logic        trap_redirect;
    logic [31:0] trap_pc;
    logic        if_stall;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_fault;

    always #5 clk = ~clk;

    dtcore32_fetch_unit #(
        .RESET_PC  (RPC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .EX_pc_src_i     (ex_pc_src),
        .EX_pc_target_i  (ex_pc_target),
        .trap_redirect_i (trap_redirect),
        .trap_pc_i       (trap_pc),
        .IF_stall_i      (if_stall),
        .imem_req_valid_o(req_valid),
        .imem_req_ready_i(req_ready),
        .imem_req_addr_o (req_addr),
        .imem_rsp_valid_i(rsp_valid),
        .imem_rsp_rdata_i(rsp_rdata),
        .imem_rsp_err_i  (rsp_err),
        .ID_valid_o      (id_valid),
        .ID_instr_o      (id_instr),
        .ID_pc_o         (id_pc),
        .ID_pc_plus_4_o  (id_pc4),
        .ID_fetch_fault_o(id_fault)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Memory model: pending requests in issue order; stale ones were overtaken by a redirect.
    logic [31:0] q_addr[$];
    int          q_due[$];
    bit          q_stale[$];
    int          lat      = 1;
    int          last_due = 0;

    // Program-order reference: next request address, next instruction ID must see, and how many
    // valid (non-stale) instructions are buffered between memory and ID.
    logic [31:0] req_exp;
    logic [31:0] id_exp;
    int          buffered  = 0;
    bit          hold      = 1'b0;
    bit          after_rst = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return (a == 32'h0000_010C) || (a[6:2] == 5'h1D);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit          redir, acc, cons, stale_now;
        logic [31:0] tgt;
        @(negedge clk);
        redir = ex_pc_src | trap_redirect;
        if (after_rst) begin
            chk("rst_req_valid", 32'(req_valid), 32'd0);
            chk("rst_req_addr", req_addr, RPC);
            chk("rst_id_valid", 32'(id_valid), 32'd0);
            chk("rst_id_instr", id_instr, 32'd0);
            chk("rst_id_pc", id_pc, 32'd0);
            chk("rst_id_pc4", id_pc4, 32'd0);
            chk("rst_id_fault", 32'(id_fault), 32'd0);
            after_rst = 1'b0;
        end
        if (!rst) begin
            chk("req_valid", 32'(req_valid),
                32'(!hold && !redir && (q_addr.size() + buffered < DEPTH)));
            if (req_valid) chk("req_addr", req_addr, req_exp);
            chk("id_valid", 32'(id_valid), 32'(buffered > 0));
            if (buffered > 0) begin
                chk("id_pc", id_pc, id_exp);
                chk("id_instr", id_instr, is_err(id_exp) ? 32'd0 : mem_word(id_exp));
                chk("id_fault", 32'(id_fault), 32'(is_err(id_exp)));
                chk("id_pc4", id_pc4, id_exp + 32'd4);
            end
        end
        acc  = req_valid & req_ready;
        cons = id_valid & ~if_stall & ~redir;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q_addr.delete();
            q_due.delete();
            q_stale.delete();
            buffered  = 0;
            req_exp   = RPC;
            id_exp    = RPC;
            hold      = 1'b1;
            after_rst = 1'b1;
        end else begin
            stale_now = 1'b1;
            if (rsp_valid) begin
                stale_now = q_stale[0];
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
                void'(q_stale.pop_front());
            end
            if (acc) begin
                last_due = (cyc + lat - 1 > last_due) ? cyc + lat - 1 : last_due + 1;
                q_addr.push_back(req_exp);
                q_due.push_back(last_due);
                q_stale.push_back(1'b0);
                req_exp = req_exp + 32'd4;
            end
            if (redir) begin
                tgt = trap_redirect ? trap_pc : ex_pc_target;
                tgt[1:0] = 2'b00;
                foreach (q_stale[i]) q_stale[i] = 1'b1;
                buffered = 0;
                req_exp  = tgt;
                id_exp   = tgt;
            end else begin
                if (rsp_valid && !stale_now) buffered++;
                if (cons) begin
                    buffered--;
                    id_exp = id_exp + 32'd4;
                end
            end
            hold = 1'b0;
        end
        #1;
        rsp_valid = (q_addr.size() > 0) && (q_due[0] <= cyc);
        rsp_rdata = rsp_valid ? mem_word(q_addr[0]) : 32'd0;
        rsp_err   = rsp_valid ? is_err(q_addr[0]) : 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic redirect(input bit ex, input logic [31:0] ex_t, input bit tr,
                            input logic [31:0] tr_t);
        ex_pc_src     = ex;
        ex_pc_target  = ex_t;
        trap_redirect = tr;
        trap_pc       = tr_t;
        tick();
        ex_pc_src     = 1'b0;
        trap_redirect = 1'b0;
    endtask

    // Bounded wait for the next ID instruction, then compare its PC.
    task automatic expect_next_id(input string tag, input logic [31:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (id_valid) found = 1'b1;
            else tick();
        end
        chk(tag, found ? id_pc : 32'hDEAD_BEEF, pc);
    endtask

    initial begin
        logic [31:0] held;
        bit          wrapped;
        rst           = 1'b1;
        ex_pc_src     = 1'b0;
        ex_pc_target  = 32'd0;
        trap_redirect = 1'b0;
        trap_pc       = 32'd0;
        if_stall      = 1'b0;
        req_ready     = 1'b1;
        rsp_valid     = 1'b0;
        rsp_rdata     = 32'd0;
        rsp_err       = 1'b0;
        req_exp       = RPC;
        id_exp        = RPC;

        // Reset, latency 1, no stall; 0x10C returns an access fault.
        ticks(2);
        rst = 1'b0;
        ticks(14);

        // Stall ID for 5 cycles while the FIFO fills, then release.
        if_stall = 1'b1;
        ticks(5);
        chk("stall_full_no_req", 32'(req_valid), 32'd0);
        if_stall = 1'b0;
        ticks(6);

        // Latency 3: redirect to 0x200 with two requests in flight.
        lat = 3;
        for (int i = 0; i < 10 && q_addr.size() < 2; i++) tick();
        chk("two_outstanding", 32'(q_addr.size()), 32'd2);
        redirect(1'b1, 32'h0000_0200, 1'b0, 32'd0);
        expect_next_id("branch_target", 32'h0000_0200);
        ticks(6);

        // Trap and branch together: trap wins.
        redirect(1'b1, 32'h0000_0300, 1'b1, 32'h0000_0080);
        expect_next_id("trap_priority", 32'h0000_0080);
        ticks(4);

        // Back-to-back redirects, the second (unaligned) one wins.
        ex_pc_src = 1'b1;
        ex_pc_target = 32'h0000_0400;
        tick();
        redirect(1'b1, 32'h0000_0503, 1'b0, 32'd0);
        expect_next_id("back_to_back", 32'h0000_0500);
        ticks(4);

        // Memory not ready for 4 cycles: address must hold.
        lat = 1;
        req_ready = 1'b0;
        held = req_addr;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("addr_hold", req_addr, held);
        end
        req_ready = 1'b1;
        ticks(3);

        // PC wrap past 0xFFFF_FFFC.
        redirect(1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0);
        wrapped = 1'b0;
        for (int i = 0; i < 30 && !wrapped; i++) begin
            if (id_valid && id_pc == 32'd0) wrapped = 1'b1;
            else tick();
        end
        chk("pc_wrap", 32'(wrapped), 32'd1);
        ticks(3);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            req_ready     = ($urandom_range(0, 3) != 0);
            if_stall      = ($urandom_range(0, 3) == 0);
            ex_pc_src     = ($urandom_range(0, 19) == 0);
            trap_redirect = ($urandom_range(0, 39) == 0);
            ex_pc_target  = $urandom_range(0, 32'h0000_0FFF);
            trap_pc       = $urandom_range(0, 32'h0000_0FFF);
            tick();
        end
        ex_pc_src     = 1'b0;
        trap_redirect = 1'b0;
        if_stall      = 1'b0;
        req_ready     = 1'b1;
        ticks(2);

        // Reset mid-stream, memory model cleared alongside.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_next_id("post_reset", RPC);
        ticks(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
